// File: rtl/risc_pkg.sv
// Shared types for the data load/store unit: access-size encoding and FSM states.
package risc_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'b00,
        HALF   = 2'b01,
        WORD   = 2'b10,
        DOUBLE = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        DONE
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for data_lsu: byte enables for both beats, store-data
// rotation, read-data merge/rotation and sign/zero extension.
module lsu_align
    import risc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   addr,
    input  size_e             size,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [XLEN-1:0]   beat0_data,
    input  logic [XLEN-1:0]   beat1_data,
    input  logic              zero_extnd,
    output logic              misaligned,
    output logic [XLEN/8-1:0] be0,
    output logic [XLEN/8-1:0] be1,
    output logic [XLEN-1:0]   addr0,
    output logic [XLEN-1:0]   addr1,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    logic [OW-1:0]     off;
    logic [OW+2:0]     sh;
    logic [3:0]        nbytes;
    logic [2*NB-1:0]   size_lanes;
    logic [2*NB-1:0]   lanes;
    logic [XLEN-1:0]   lane0_mask;
    logic [XLEN-1:0]   ext_mask;
    logic [XLEN-1:0]   merged;
    logic [XLEN-1:0]   rot;
    logic [2*XLEN-1:0] wrot;
    logic [2*XLEN-1:0] rrot;
    logic              sign;

    assign off   = addr[OW-1:0];
    assign sh    = {off, 3'b000};
    assign addr0 = {addr[XLEN-1:OW], {OW{1'b0}}};
    assign addr1 = addr0 + XLEN'(NB);

    always_comb begin
        case (size)
            BYTE:    nbytes = 4'd1;
            HALF:    nbytes = 4'd2;
            WORD:    nbytes = 4'd4;
            default: nbytes = 4'(NB);   // a double on a 32-bit datapath is a word
        endcase

        size_lanes = '0;
        for (int i = 0; i < 2 * NB; i++) size_lanes[i] = (4'(i) < nbytes);
        // Lanes past the top of beat 0 spill into the low lanes of beat 1.
        lanes      = size_lanes << off;
        be0        = lanes[NB-1:0];
        be1        = lanes[2*NB-1:NB];
        misaligned = |be1;

        wrot  = {wr_data, wr_data} << sh;
        wdata = wrot[2*XLEN-1:XLEN];

        lane0_mask = '0;
        ext_mask   = '0;
        for (int i = 0; i < NB; i++) begin
            lane0_mask[8*i +: 8] = {8{be0[i]}};
            ext_mask[8*i +: 8]   = {8{4'(i) < nbytes}};
        end
        merged = (beat0_data & lane0_mask) | (beat1_data & ~lane0_mask);
        rrot   = {merged, merged} >> sh;
        rot    = rrot[XLEN-1:0];

        sign = 1'b0;
        for (int i = 0; i < NB; i++) if (4'(i + 1) == nbytes) sign = rot[8*i+7];
        rdata = (rot & ext_mask) | ({XLEN{sign & ~zero_extnd}} & ~ext_mask);
    end

endmodule

// File: rtl/data_lsu.sv
// Data load/store unit: one- or two-beat memory access FSM with result register.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses; otherwise they end in error.
module data_lsu
    import risc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              data_req_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [1:0]        data_byte_en_i,
    input  logic              data_wr_i,
    input  logic [XLEN-1:0]   data_wr_data_i,
    input  logic              data_zero_extnd_i,
    output logic              data_done_o,
    output logic              data_err_o,
    output logic              data_busy_o,
    output logic [XLEN-1:0]   data_mem_rd_data_o,
    output logic              data_mem_req_o,
    input  logic              data_mem_gnt_i,
    output logic [XLEN-1:0]   data_mem_addr_o,
    output logic [XLEN/8-1:0] data_mem_be_o,
    output logic              data_mem_wr_o,
    output logic [XLEN-1:0]   data_mem_wr_data_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rd_data_i
);
    localparam int NB = XLEN / 8;

    lsu_state_e      state, next_state;
    logic [XLEN-1:0] addr_q, wdata_q, rd_q;
    size_e           size_q;
    logic            wr_q, zext_q, err_q;
    logic [XLEN-1:0] cur_addr, beat0_data, addr0, addr1, wdata_rot, rdata;
    size_e           cur_size;
    logic [NB-1:0]   be0, be1;
    logic            misaligned, acc_err, load_done;

    // While idle the aligner sees the incoming request so misalignment is known at accept.
    assign cur_addr = (state == IDLE) ? data_addr_i : addr_q;
    assign cur_size = (state == IDLE) ? size_e'(data_byte_en_i) : size_q;

`ifdef MISALIGNED_SPLIT_EN
    logic [XLEN-1:0] beat0_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            beat0_q <= '0;
        else if (state == WAIT0 && mem_rvalid_i) beat0_q <= mem_rd_data_i;
    end

    assign beat0_data = (state == WAIT1) ? beat0_q : mem_rd_data_i;
    assign acc_err    = 1'b0;
`else
    assign beat0_data = mem_rd_data_i;
    assign acc_err    = misaligned;
`endif

    lsu_align #(.XLEN(XLEN)) u_align (
        .addr       (cur_addr),
        .size       (cur_size),
        .wr_data    (wdata_q),
        .beat0_data (beat0_data),
        .beat1_data (mem_rd_data_i),
        .zero_extnd (zext_q),
        .misaligned (misaligned),
        .be0        (be0),
        .be1        (be1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata      (wdata_rot),
        .rdata      (rdata)
    );

    assign load_done = mem_rvalid_i && !wr_q &&
                       ((state == WAIT1) || (state == WAIT0 && !misaligned));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= BYTE;
            wr_q    <= 1'b0;
            zext_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            if (state == IDLE && data_req_i) begin
                addr_q  <= data_addr_i;
                wdata_q <= data_wr_data_i;
                size_q  <= size_e'(data_byte_en_i);
                wr_q    <= data_wr_i;
                zext_q  <= data_zero_extnd_i;
                err_q   <= acc_err;
            end
            if (load_done) rd_q <= rdata;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (data_req_i)     next_state = acc_err ? DONE : REQ0;
            REQ0:  if (data_mem_gnt_i) next_state = WAIT0;
`ifdef MISALIGNED_SPLIT_EN
            WAIT0: if (mem_rvalid_i)   next_state = misaligned ? REQ1 : DONE;
            REQ1:  if (data_mem_gnt_i) next_state = WAIT1;
            WAIT1: if (mem_rvalid_i)   next_state = DONE;
`else
            WAIT0: if (mem_rvalid_i)   next_state = DONE;
`endif
            DONE:                      next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    always_comb begin
        data_busy_o        = (state != IDLE);
        data_done_o        = (state == DONE);
        data_err_o         = (state == DONE) && err_q;
        data_mem_req_o     = 1'b0;
        data_mem_addr_o    = '0;
        data_mem_be_o      = '0;
        data_mem_wr_o      = 1'b0;
        data_mem_wr_data_o = '0;
        if (state == REQ0 || state == REQ1) begin
            data_mem_req_o     = 1'b1;
            data_mem_addr_o    = (state == REQ1) ? addr1 : addr0;
            data_mem_be_o      = (state == REQ1) ? be1 : be0;
            data_mem_wr_o      = wr_q;
            data_mem_wr_data_o = wdata_rot;
        end
    end

    assign data_mem_rd_data_o = rd_q;

endmodule

// File: tb/tb_data_lsu.sv
// Self-checking bench for data_lsu (XLEN=32): directed vectors, multi-cycle corner
// sequences and random traffic against a byte-level memory model.
`timescale 1ns/1ps
module tb_data_lsu;
    localparam int XLEN = 32;
`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_req_i = 0, data_wr_i = 0, data_zero_extnd_i = 0;
    logic [31:0] data_addr_i = '0, data_wr_data_i = '0;
    logic [1:0]  data_byte_en_i = '0;
    logic        data_done_o, data_err_o, data_busy_o;
    logic [31:0] data_mem_rd_data_o, data_mem_addr_o, data_mem_wr_data_o;
    logic        data_mem_req_o, data_mem_wr_o;
    logic        data_mem_gnt_i = 0, mem_rvalid_i = 0;
    logic [3:0]  data_mem_be_o;
    logic [31:0] mem_rd_data_i = '0;

    data_lsu #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_byte_en_i(data_byte_en_i),
        .data_wr_i(data_wr_i), .data_wr_data_i(data_wr_data_i), .data_zero_extnd_i(data_zero_extnd_i),
        .data_done_o(data_done_o), .data_err_o(data_err_o), .data_busy_o(data_busy_o),
        .data_mem_rd_data_o(data_mem_rd_data_o),
        .data_mem_req_o(data_mem_req_o), .data_mem_gnt_i(data_mem_gnt_i),
        .data_mem_addr_o(data_mem_addr_o), .data_mem_be_o(data_mem_be_o),
        .data_mem_wr_o(data_mem_wr_o), .data_mem_wr_data_o(data_mem_wr_data_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rd_data_i(mem_rd_data_i)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem_dut [256];
    logic [7:0]  mem_ref [256];
    int          n_chk = 0, n_fail = 0;
    int          done_cyc, nbeats, unstable;
    logic        got_err, post_ok;
    logic [31:0] got_rd, held_rd;
    logic [31:0] b_addr [2];
    logic [3:0]  b_be [2];
    logic [31:0] b_wd [2];

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        zx;
        logic [31:0] word;
        logic [3:0]  be;
        logic [31:0] rd;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int ref_n(input logic [1:0] sz);
        return (sz == 2'd3) ? 4 : (1 << sz);
    endfunction

    function automatic bit ref_mis(input logic [31:0] a, input logic [1:0] sz);
        return (int'(a[1:0]) + ref_n(sz)) > 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic zx);
        logic [31:0] v = '0;
        logic [7:0]  idx;
        int          n = ref_n(sz);
        for (int k = 0; k < n; k++) begin
            idx = 8'(a + 32'(k));
            v[8*k +: 8] = mem_ref[idx];
        end
        if (!zx && v[8*n-1]) for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic void ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [7:0] idx;
        for (int k = 0; k < ref_n(sz); k++) begin
            idx = 8'(a + 32'(k));
            mem_ref[idx] = wd[8*k +: 8];
        end
    endfunction

    function automatic void put_word(input logic [31:0] a, input logic [31:0] w);
        logic [7:0] idx;
        for (int k = 0; k < 4; k++) begin
            idx = 8'(a + 32'(k));
            mem_dut[idx] = w[8*k +: 8];
            mem_ref[idx] = w[8*k +: 8];
        end
    endfunction

    // Drives one access and plays the memory side; called and returns at a negedge in IDLE.
    task automatic run_access(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                              input logic [31:0] wd, input logic zx, input int g, input int r);
        int          gcnt = 0, rcnt = 0;
        bit          pend = 0, fresh = 1;
        logic [31:0] rword = '0;
        logic [7:0]  idx;
        data_req_i = 1; data_addr_i = a; data_byte_en_i = sz;
        data_wr_i = wr; data_wr_data_i = wd; data_zero_extnd_i = zx;
        done_cyc = -1; nbeats = 0; unstable = 0; got_err = 0; got_rd = '0; post_ok = 0;
        @(posedge clk);
        for (int cyc = 1; cyc < 64 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            data_mem_gnt_i = 0; mem_rvalid_i = 0; mem_rd_data_i = $urandom;
            if (data_done_o) begin
                done_cyc = cyc; got_err = data_err_o; got_rd = data_mem_rd_data_o; data_req_i = 0;
            end else if (data_mem_req_o) begin
                if (fresh) begin
                    if (nbeats < 2) begin
                        b_addr[nbeats] = data_mem_addr_o; b_be[nbeats] = data_mem_be_o;
                        b_wd[nbeats] = data_mem_wr_data_o;
                    end
                    nbeats++; fresh = 0; gcnt = 0;
                end else if (nbeats <= 2 && {data_mem_addr_o, data_mem_be_o, data_mem_wr_data_o} !==
                             {b_addr[nbeats-1], b_be[nbeats-1], b_wd[nbeats-1]}) begin
                    unstable++;
                end
                if (gcnt == g) begin
                    data_mem_gnt_i = 1; pend = 1; rcnt = 1; fresh = 1;
                    for (int k = 0; k < 4; k++) begin
                        idx = 8'(data_mem_addr_o + 32'(k));
                        rword[8*k +: 8] = mem_dut[idx];
                        if (data_mem_wr_o && data_mem_be_o[k]) mem_dut[idx] = data_mem_wr_data_o[8*k +: 8];
                    end
                end else begin
                    gcnt++;
                    mem_rvalid_i = 1'($urandom_range(0, 1));
                end
            end else if (pend) begin
                if (rcnt == r) begin
                    mem_rvalid_i = 1; mem_rd_data_i = rword; pend = 0;
                end else begin
                    rcnt++;
                    data_mem_gnt_i = 1'($urandom_range(0, 1));
                end
            end
        end
        data_req_i = 0;
        @(negedge clk);
        data_mem_gnt_i = 0; mem_rvalid_i = 0;
        post_ok = !data_done_o && !data_busy_o;
    endtask

    task automatic do_check(input string nm, input logic [31:0] a, input logic [1:0] sz, input logic wr,
                            input logic [31:0] wd, input logic zx, input int g, input int r);
        bit mis   = ref_mis(a, sz);
        bit err   = mis && !SPLIT;
        int beats = err ? 0 : (mis ? 2 : 1);
        int lat   = err ? 1 : (mis ? 3 + 2*g + 2*r : 2 + g + r);
        if (!err && !wr) held_rd = ref_load(a, sz, zx);
        if (!err && wr) ref_store(a, sz, wd);
        run_access(a, sz, wr, wd, zx, g, r);
        chk({nm, " done_cycle"}, 64'(done_cyc), 64'(lat));
        chk({nm, " err"}, got_err, err);
        chk({nm, " rd_data"}, got_rd, held_rd);
        chk({nm, " beats"}, nbeats, beats);
        chk({nm, " stable"}, unstable, 0);
        chk({nm, " single_done"}, post_ok, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seen;
        int         diff;
        vt[0] = '{32'h103, 2'b00, 1'b0, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80};
        vt[1] = '{32'h102, 2'b01, 1'b1, 32'hBEEF_0000, 4'b1100, 32'h0000_BEEF};
        vt[2] = '{32'h104, 2'b10, 1'b0, 32'h1234_5678, 4'b1111, 32'h1234_5678};
        vt[3] = '{32'h100, 2'b01, 1'b0, 32'h0000_8001, 4'b0011, 32'hFFFF_8001};
        vt[4] = '{32'h101, 2'b00, 1'b1, 32'h0000_9A00, 4'b0010, 32'h0000_009A};
        vt[5] = '{32'h108, 2'b11, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};
        for (int i = 0; i < 256; i++) begin
            mem_dut[i] = 8'($urandom);
            mem_ref[i] = mem_dut[i];
        end
        held_rd = '0;

        #1;
        chk("reset ctl", {data_done_o, data_err_o, data_busy_o, data_mem_req_o, data_mem_wr_o, data_mem_be_o}, 0);
        chk("reset rd_data", data_mem_rd_data_o, 0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            put_word({vt[i].addr[31:2], 2'b00}, vt[i].word);
            do_check($sformatf("vec%0d", i), vt[i].addr, vt[i].sz, 1'b0, '0, vt[i].zx, 0, 1);
            chk($sformatf("vec%0d be", i), b_be[0], vt[i].be);
            chk($sformatf("vec%0d beat_addr", i), b_addr[0], {vt[i].addr[31:2], 2'b00});
            chk($sformatf("vec%0d literal", i), got_rd, vt[i].rd);
        end

        // Misaligned word store straddling 0x100
        do_check("sw_0fe", 32'h0FE, 2'b10, 1'b1, 32'hAABB_CCDD, 1'b0, 0, 1);
`ifdef MISALIGNED_SPLIT_EN
        chk("sw_0fe beat0 addr", b_addr[0], 32'h0FC);
        chk("sw_0fe beat0 be", b_be[0], 4'b1100);
        chk("sw_0fe beat1 addr", b_addr[1], 32'h100);
        chk("sw_0fe beat1 be", b_be[1], 4'b0011);
        chk("sw_0fe wdata0", b_wd[0], 32'hCCDD_AABB);
        chk("sw_0fe wdata1", b_wd[1], 32'hCCDD_AABB);
`else
        chk("sw_0fe err", got_err, 1);
        chk("sw_0fe no mem req", nbeats, 0);
`endif

        // Grant held off three cycles, response two cycles after grant
        do_check("lw_slow", 32'h010, 2'b10, 1'b0, '0, 1'b0, 3, 2);

        // Reset while a granted read is outstanding; its late response must vanish
        data_req_i = 1; data_addr_i = 32'h40; data_byte_en_i = 2'b10; data_wr_i = 0;
        @(posedge clk);
        @(negedge clk); data_mem_gnt_i = 1;
        @(negedge clk); data_mem_gnt_i = 0;
        chk("busy in wait0", data_busy_o, 1);
        reset_n = 0;
        #1;
        chk("midop reset ctl", {data_done_o, data_err_o, data_busy_o, data_mem_req_o, data_mem_wr_o, data_mem_be_o}, 0);
        chk("midop reset rd_data", data_mem_rd_data_o, 0);
        chk("midop reset addr/wdata", {data_mem_addr_o, data_mem_wr_data_o}, 0);
        data_req_i = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        mem_rvalid_i = 1; mem_rd_data_i = 32'h1234_5678;
        seen = '0;
        repeat (4) begin
            @(negedge clk);
            mem_rvalid_i = 0;
            seen = seen | {data_done_o, data_busy_o, data_mem_req_o, data_err_o};
        end
        chk("late rvalid ignored", seen, 0);
        chk("rd_data after reset", data_mem_rd_data_o, 0);
        held_rd = '0;

        for (int i = 0; i < 80; i++) begin
            do_check($sformatf("rnd%0d", i), 32'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(1, 3));
        end

        diff = 0;
        for (int i = 0; i < 256; i++) if (mem_dut[i] !== mem_ref[i]) diff++;
        chk("memory image", diff, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_lsu.md
DATA_LSU -- requirements
Module: data_lsu

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 data_req_i  input  1  core access request; held until data_done_o.
REQ-005 data_addr_i  input  XLEN  byte address.
REQ-006 data_byte_en_i  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-007 data_wr_i / data_wr_data_i  input  1 / XLEN  store flag / store data, LSB-justified.
REQ-008 data_zero_extnd_i  input  1  1 = zero-extend load, 0 = sign-extend.
REQ-009 data_done_o / data_err_o / data_busy_o  output  1 each  completion pulse / error with done / FSM not IDLE.
REQ-010 data_mem_rd_data_o  output  XLEN  extended load result, valid with data_done_o.
REQ-011 data_mem_req_o / data_mem_gnt_i  output / input  1 / 1  memory request / grant.
REQ-012 data_mem_addr_o  output  XLEN  beat address, XLEN/8-aligned.
REQ-013 data_mem_be_o  output  XLEN/8  byte-lane enables.
REQ-014 data_mem_wr_o / data_mem_wr_data_o  output  1 / XLEN  write flag / lane-aligned write data.
REQ-015 mem_rvalid_i / mem_rd_data_i  input  1 / XLEN  response strobe (reads and writes) / read data.

Function
REQ-016 FSM states SHALL be IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
REQ-017 IDLE + data_req_i: latch addr/size/wr/data/ext; go REQ0, or DONE with error if misaligned and split disabled.
REQ-018 REQ0/REQ1: data_mem_req_o=1, addr/be/wr/wdata stable until data_mem_gnt_i; on grant go WAIT0/WAIT1.
REQ-019 WAIT0 + mem_rvalid_i: go REQ1 if split access, else DONE; WAIT1 + mem_rvalid_i: go DONE.
REQ-020 DONE: data_done_o=1 for exactly one cycle, then IDLE; data_req_i SHALL be ignored in DONE.
REQ-021 Minimum latency: request accepted cycle 0, mem req cycle 1, rvalid cycle 2, done cycle 3.
REQ-022 Size 11 with XLEN=32 SHALL behave as word access.
REQ-023 Offset = addr mod XLEN/8; beat-0 be = size mask shifted left by offset, truncated to XLEN/8 lanes.
REQ-024 Misaligned = offset + size bytes > XLEN/8; beat 1 at aligned addr + XLEN/8 (modulo 2^XLEN) carries remaining low lanes.
REQ-025 Write data SHALL be data rotated left by 8*offset bits, identical on both beats.
REQ-026 Read data SHALL be rotated right by 8*offset from beat-0 lanes and beat-1 lanes, then masked to size and sign/zero-extended to XLEN; registered, held until next done.
REQ-027 mem_rvalid_i outside WAIT0/WAIT1 and data_mem_gnt_i outside REQ0/REQ1 SHALL be ignored.
REQ-028 data_err_o SHALL be 0 on every non-error completion; erroneous access issues no memory request.

Reset
REQ-029 Reset SHALL force IDLE; all outputs 0, including data_mem_rd_data_o, at any point mid-operation.
REQ-030 Responses to a beat granted before reset SHALL be discarded.

Configuration
REQ-031 With MISALIGNED_SPLIT_EN defined, misaligned accesses SHALL be split into two beats per REQ-024.
REQ-032 Without MISALIGNED_SPLIT_EN, misaligned accesses SHALL complete via DONE with data_err_o=1, data_mem_rd_data_o unchanged; REQ1/WAIT1 are not built.

Structure
REQ-033 Package risc_pkg SHALL hold the access-size enum (BYTE/HALF/WORD/DOUBLE) and FSM state typedef.
REQ-034 Combinational lane, rotate and extension logic SHALL be sub-module lsu_align; data_lsu holds FSM and registers.

Verification (XLEN=32)
REQ-035 LB signed, addr 0x103, read 0x80FF_1234 -> be 4'b1000, result 0xFFFF_FF80, done cycle 3.
REQ-036 LHU addr 0x102, read 0xBEEF_0000 -> be 4'b1100, result 0x0000_BEEF.
REQ-037 SW addr 0x0FE, data 0xAABBCCDD, split enabled -> beat0 0x0FC be 1100, beat1 0x100 be 0011, wdata 0xCCDDAABB, err 0.
REQ-038 Same store, split disabled -> no data_mem_req_o, done and err 1 in cycle 1.
REQ-039 Grant withheld 3 cycles, rvalid 2 cycles after grant -> request fields stable, done one cycle after rvalid.
REQ-040 reset_n low in WAIT0, late rvalid after release -> outputs 0, FSM IDLE, no done pulse.
